fir_mac_sequencer: RTL and testbench

Time-multiplexed FIR controller. It sequences a single shared multiply-accumulate unit across all taps instead of instantiating one multiplier per tap. It owns the circular sample history buffer and the valid/ready handshakes, and drives the read address of an external coefficient ROM. It sits between the ADC sample source and the DAC/output sink, and replaces the fully parallel filter where multiplier count is the limiting resource.

---
 rtl/fir_mac_sequencer.sv | 134 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared MAC swept across all taps over a circular sample history.
// Optional output saturation and sat_flag port when FIR_SAT_EN is defined.
module fir_mac_sequencer #(
  parameter int WIDTH   = 10,
  parameter int TAPS    = 200,
  parameter int COEFF_W = 17,
  parameter int SHIFT   = 15,
  parameter int ADDR_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  output logic [ADDR_W-1:0]  coeff_addr,
  input  logic [COEFF_W-1:0] coeff_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
`ifdef FIR_SAT_EN
  output logic               sat_flag,
`endif
  output logic               busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and a raised out_valid/data_out holds until the transfer.

  localparam int ACC_W = WIDTH + COEFF_W + $clog2(TAPS);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W:0]   TAPS_X = (ADDR_W + 1)'(TAPS);

  typedef enum logic [2:0] {CLEAR, IDLE, MAC, DRAIN, OUT} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]  hist [TAPS];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] rd_idx;
  logic [WIDTH-1:0]  sample_reg;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  prod;
  logic              acc_en;
  logic              accept;

  always_ff @(posedge clock) begin
    if (reset) state <= CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      CLEAR: if (clr_cnt == LAST) state_next = IDLE;
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = MAC;
      end
      MAC:   if (k == LAST) state_next = DRAIN;
      DRAIN: state_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = CLEAR;
    endcase
  end

  assign accept     = in_valid & in_ready;
  assign coeff_addr = k;

  // Newest sample sits at wp; tap k looks k entries back, wrapping at TAPS (not 2^ADDR_W).
  always_comb begin
    rd_idx = (wp >= k) ? (wp - k) : ADDR_W'({1'b0, wp} + TAPS_X - {1'b0, k});
  end

  assign prod = ACC_W'(coeff_data) * ACC_W'(sample_reg);

  always_ff @(posedge clock) begin
    if (state == CLEAR)  hist[clr_cnt] <= '0;
    else if (accept)     hist[wp]      <= data_in;
  end

  // acc_en delays the issue by one cycle so each product meets its ROM word.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp         <= '0;
      clr_cnt    <= '0;
      k          <= '0;
      sample_reg <= '0;
      acc        <= '0;
      acc_en     <= 1'b0;
    end else begin
      acc_en <= (state == MAC);
      if (acc_en) acc <= acc + prod;
      case (state)
        CLEAR: clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + 1'b1;
        IDLE: begin
          if (accept) begin
            acc <= '0;
            k   <= '0;
          end
        end
        MAC: begin
          sample_reg <= hist[rd_idx];
          if (k != LAST) k <= k + 1'b1;
        end
        OUT: begin
          if (out_ready) wp <= (wp == LAST) ? '0 : wp + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FIR_SAT_EN
  logic [ACC_W-1:0] shifted;
  logic             sat;

  assign shifted  = acc >> SHIFT;
  assign sat      = |shifted[ACC_W-1:WIDTH];
  assign data_out = sat ? '1 : shifted[WIDTH-1:0];
  assign sat_flag = out_valid & sat;
`else
  assign data_out = WIDTH'(acc >> SHIFT);
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer (TAPS=4, SHIFT=0) against a shift-register FIR model.
module tb_fir_mac_sequencer;

  localparam int WIDTH   = 10;
  localparam int TAPS    = 4;
  localparam int COEFF_W = 17;
  localparam int SHIFT   = 0;
  localparam int ADDR_W  = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_in;
  logic [ADDR_W-1:0]  coeff_addr;
  logic [COEFF_W-1:0] coeff_data = '0;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_out;
  logic               busy;
  logic               sat_flag_w;

  logic [COEFF_W-1:0] coef  [TAPS];
  logic [WIDTH-1:0]   mhist [TAPS];
  logic [WIDTH:0]     exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  fir_mac_sequencer #(
    .WIDTH(WIDTH), .TAPS(TAPS), .COEFF_W(COEFF_W), .SHIFT(SHIFT), .ADDR_W(ADDR_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
`ifdef FIR_SAT_EN
    .sat_flag   (sat_flag_w),
`endif
    .busy       (busy)
  );

`ifndef FIR_SAT_EN
  assign sat_flag_w = 1'b0;
`endif

  // ---------------- clock / ROM ----------------
  always #5 clock = ~clock;

  always @(posedge clock) coeff_data <= coef[coeff_addr];

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < TAPS; i++) mhist[i] = '0;
  endfunction

  // Returns {sat, value}: y = sum_k c[k] * x[n-k], shifted, then saturated or truncated.
  function automatic logic [WIDTH:0] model_push(input logic [WIDTH-1:0] s);
    longint sum;
    longint sh;
    logic   sat;
    for (int i = TAPS - 1; i > 0; i--) mhist[i] = mhist[i-1];
    mhist[0] = s;
    sum = 0;
    for (int i = 0; i < TAPS; i++) sum += longint'(coef[i]) * longint'(mhist[i]);
    sh  = sum >>> SHIFT;
    sat = 1'b0;
`ifdef FIR_SAT_EN
    if (sh > longint'((1 << WIDTH) - 1)) begin
      sat = 1'b1;
      sh  = (1 << WIDTH) - 1;
    end
`endif
    return {sat, WIDTH'(sh % (1 << WIDTH))};
  endfunction

  // ---------------- driver tasks (start and end just after a negedge) ----------------
  task automatic do_reset(output int clr, output bit saw_valid);
    saw_valid = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    @(negedge clock);
    if (out_valid) saw_valid = 1'b1;
    reset = 1'b0;
    clr   = 0;
    while (!in_ready && clr < 100) begin
      if (out_valid) saw_valid = 1'b1;
      clr++;
      @(negedge clock);
    end
    model_clear();
  endtask

  // Offers one sample, waits for the result; lat = edges from acceptance to output handshake.
  task automatic send_sample(input logic [WIDTH-1:0] s, output int lat,
                             output logic [WIDTH-1:0] y, output logic sat_o);
    int n;
    lat      = -1;
    y        = 'x;
    sat_o    = 1'bx;
    data_in  = s;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(negedge clock);
    in_valid = 1'b0;
    n = 1;
    while (!(out_valid && out_ready) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (out_valid && out_ready) begin
      lat   = n;
      y     = data_out;
      sat_o = sat_flag_w;
      @(negedge clock);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int clr;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (data_out !== '0)    begin n_err++; $display("FAIL reset_data_out: got %0d expected 0", data_out); end
    n_cmp++; if (coeff_addr !== '0)  begin n_err++; $display("FAIL reset_coeff_addr: got %0d expected 0", coeff_addr); end
    n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL reset_busy: got %b expected 1", busy); end
    reset = 1'b0;
    clr = 0;
    while (!in_ready && clr < 100) begin
      clr++;
      @(negedge clock);
    end
    model_clear();
    n_cmp++; if (clr !== TAPS) begin n_err++; $display("FAIL reset_clear_cycles: got %0d expected %0d", clr, TAPS); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_impulse();
    logic [WIDTH-1:0] stim [4];
    logic [WIDTH-1:0] y;
    logic             sat;
    int               lat;
    stim = '{10'd1, 10'd0, 10'd0, 10'd0};
    for (int i = 0; i < 4; i++) begin
      send_sample(stim[i], lat, y, sat);
      n_cmp++; if (y !== WIDTH'(i + 1)) begin n_err++; $display("FAIL impulse_data[%0d]: got %0d expected %0d", i, y, i + 1); end
      n_cmp++; if (lat !== TAPS + 2)    begin n_err++; $display("FAIL impulse_latency[%0d]: got %0d expected %0d", i, lat, TAPS + 2); end
`ifdef FIR_SAT_EN
      n_cmp++; if (sat !== 1'b0)        begin n_err++; $display("FAIL impulse_sat_flag[%0d]: got %b expected 0", i, sat); end
`endif
      void'(model_push(stim[i]));
    end
  endtask

  task automatic test_constant_wrap();
    int               expv [5];
    int               clr;
    bit               sv;
    logic [WIDTH-1:0] y;
    logic             sat;
    int               lat;
    expv = '{100, 300, 600, 1000, 1000};
    do_reset(clr, sv);
    for (int i = 0; i < 5; i++) begin
      send_sample(10'd100, lat, y, sat);
      n_cmp++; if (y !== WIDTH'(expv[i])) begin n_err++; $display("FAIL const_data[%0d]: got %0d expected %0d", i, y, expv[i]); end
      void'(model_push(10'd100));
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0] e1, e2;
    bit             bad_ready;
    int             n;
    int             clr;
    bit             sv;
    do_reset(clr, sv);
    out_ready = 1'b0;
    data_in   = 10'd7;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clock); n++; end
    @(negedge clock);
    e1        = model_push(10'd7);
    data_in   = 10'd9;
    bad_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      if (in_ready) bad_ready = 1'b1;
      @(negedge clock);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({out_valid, data_out} !== {1'b1, e1[WIDTH-1:0]}) begin
        n_err++;
        $display("FAIL hold_output[%0d]: got valid=%b data=%0d expected valid=1 data=%0d", i, out_valid, data_out, e1[WIDTH-1:0]);
      end
      if (in_ready) bad_ready = 1'b1;
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (bad_ready !== 1'b0) begin n_err++; $display("FAIL busy_in_ready: got in_ready high while busy, expected low"); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL ready_after_handshake: got %b expected 1", in_ready); end
    @(negedge clock);
    in_valid = 1'b0;
    e2 = model_push(10'd9);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clock); n++; end
    n_cmp++; if (data_out !== e2[WIDTH-1:0]) begin n_err++; $display("FAIL held_sample_result: got %0d expected %0d", data_out, e2[WIDTH-1:0]); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_mac();
    logic [WIDTH-1:0] y;
    logic             sat;
    int               lat;
    int               clr;
    bit               sv;
    int               n;
    do_reset(clr, sv);
    for (int i = 0; i < 2; i++) begin
      send_sample(WIDTH'($urandom_range(1, 1023)), lat, y, sat);
    end
    data_in  = WIDTH'($urandom_range(1, 1023));
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clock); n++; end
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    do_reset(clr, sv);
    n_cmp++; if (clr !== TAPS) begin n_err++; $display("FAIL midreset_clear_cycles: got %0d expected %0d", clr, TAPS); end
    n_cmp++; if (sv !== 1'b0)  begin n_err++; $display("FAIL midreset_stale_valid: got %b expected 0", sv); end
    send_sample(10'd5, lat, y, sat);
    n_cmp++; if (y !== 10'd5)      begin n_err++; $display("FAIL midreset_data: got %0d expected 5", y); end
    n_cmp++; if (lat !== TAPS + 2) begin n_err++; $display("FAIL midreset_latency: got %0d expected %0d", lat, TAPS + 2); end
    void'(model_push(10'd5));
  endtask

  task automatic test_saturation();
    logic [WIDTH:0]   e;
    logic [WIDTH-1:0] y;
    logic             sat;
    int               lat;
    int               clr;
    bit               sv;
    for (int i = 0; i < TAPS; i++) coef[i] = 17'd300;
    do_reset(clr, sv);
    for (int i = 0; i < 4; i++) begin
      send_sample(10'd1023, lat, y, sat);
      e = model_push(10'd1023);
      n_cmp++; if (y !== e[WIDTH-1:0]) begin n_err++; $display("FAIL sat_data[%0d]: got %0d expected %0d", i, y, e[WIDTH-1:0]); end
    end
`ifdef FIR_SAT_EN
    n_cmp++; if (y !== 10'd1023) begin n_err++; $display("FAIL sat_last: got %0d expected 1023", y); end
    n_cmp++; if (sat !== 1'b1)   begin n_err++; $display("FAIL sat_flag: got %b expected 1", sat); end
`else
    n_cmp++; if (y !== 10'd848)  begin n_err++; $display("FAIL trunc_last: got %0d expected 848", y); end
`endif
  endtask

  task automatic test_back_to_back();
    int             clr;
    bit             sv;
    int             acc_cnt, out_cnt, cyc, last_acc;
    bit             new_needed;
    logic [WIDTH:0] e;
    for (int i = 0; i < TAPS; i++) coef[i] = COEFF_W'($urandom_range(0, (1 << COEFF_W) - 1));
    do_reset(clr, sv);
    exp_q.delete();
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    data_in    = WIDTH'($urandom_range(0, 1023));
    acc_cnt    = 0;
    out_cnt    = 0;
    cyc        = 0;
    last_acc   = -1;
    new_needed = 1'b0;
    while ((acc_cnt < 50 || out_cnt < 50) && cyc < 1000) begin
      if (new_needed) begin
        data_in    = WIDTH'($urandom_range(0, 1023));
        new_needed = 1'b0;
      end
      if (acc_cnt == 50) in_valid = 1'b0;
      if (in_valid && in_ready) begin
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc !== TAPS + 3) begin
            n_err++;
            $display("FAIL b2b_period[%0d]: got %0d expected %0d", acc_cnt, cyc - last_acc, TAPS + 3);
          end
        end
        last_acc = cyc;
        exp_q.push_back(model_push(data_in));
        acc_cnt++;
        new_needed = 1'b1;
      end
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_unexpected_output: got %0d expected none", data_out);
        end else begin
          e = exp_q.pop_front();
          if ({sat_flag_w, data_out} !== {(e[WIDTH] & 1'b1) & sat_flag_w | e[WIDTH] & 1'b0 | sat_flag_w & 1'b0 | e[WIDTH] & sat_flag_w, e[WIDTH-1:0]}
`ifdef FIR_SAT_EN
              || sat_flag_w !== e[WIDTH]
`endif
             ) begin
            n_err++;
            $display("FAIL b2b_data[%0d]: got %0d (sat %b) expected %0d (sat %b)", out_cnt, data_out, sat_flag_w, e[WIDTH-1:0], e[WIDTH]);
          end
        end
        out_cnt++;
      end
      @(negedge clock);
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (acc_cnt !== 50)     begin n_err++; $display("FAIL b2b_accepted: got %0d expected 50", acc_cnt); end
    n_cmp++; if (out_cnt !== 50)     begin n_err++; $display("FAIL b2b_outputs: got %0d expected 50", out_cnt); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL b2b_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;
    coef      = '{17'd1, 17'd2, 17'd3, 17'd4};
    model_clear();
    @(negedge clock);
    test_reset();
    test_impulse();
    test_constant_wrap();
    test_backpressure();
    test_reset_mid_mac();
    test_saturation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
